// File: rtl/load_pkg.sv
// Shared definitions for the load alignment unit.
// funct3 encodings, FSM states and size/legality helpers.
package load_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        WAIT0,
        REQ1,
        WAIT1,
        DONE
    } loadState_e;

    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        return 4'd1 << funct3[1:0];
    endfunction

    function automatic logic funct3Legal(
        input logic [2:0] funct3,
        input logic       is64
    );
        logic ok;
        unique case (funct3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
            F3_LD, F3_LWU:                       ok = is64;
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Byte selection and sign/zero extension of a load result
// taken from a two-word little-endian window.
module load_extract
    import load_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0]         words,
    input  logic [$clog2(XLEN/8)-1:0] off,
    input  logic [2:0]                funct3,
    output logic [XLEN-1:0]           data
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = XLEN'(words >> {off, 3'b000});
        case (funct3[1:0])
            2'b00: begin
                data = funct3[2] ? XLEN'(shifted[7:0])
                                 : XLEN'($signed(shifted[7:0]));
            end
            2'b01: begin
                data = funct3[2] ? XLEN'(shifted[15:0])
                                 : XLEN'($signed(shifted[15:0]));
            end
            2'b10: begin
                data = funct3[2] ? XLEN'(shifted[31:0])
                                 : XLEN'($signed(shifted[31:0]));
            end
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/load_align_unit.sv
// Load unit: issues one or two aligned word reads per request and
// returns the aligned, extended result over a valid/ready handshake.
module load_align_unit
    import load_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_data,
    output logic              rsp_err
);

    localparam int   NB    = XLEN / 8;
    localparam int   OFF_W = $clog2(NB);
    localparam logic IS64  = (XLEN == 64);

    loadState_e        state;
    logic [OFF_W-1:0]  offQ;
    logic [2:0]        f3Q;
    logic              crossQ;
    logic [XLEN-1:0]   word0;

    logic [OFF_W-1:0]  reqOff;
    logic [4:0]        reqEnd;
    logic              reqCross;
    logic              reqLegal;
    logic [ADDR_W-1:0] reqAligned;
    logic [XLEN-1:0]   wordHi;
    logic [XLEN-1:0]   wordLo;
    logic [XLEN-1:0]   extData;

    assign reqOff     = req_addr[OFF_W-1:0];
    assign reqEnd     = 5'(reqOff) + 5'(size_bytes(req_funct3));
    assign reqCross   = reqEnd > 5'(NB);
    assign reqLegal   = funct3Legal(req_funct3, IS64);
    assign reqAligned = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // The final word is taken straight off the bus so the result
    // can be registered in the same cycle it arrives.
    assign wordHi = (state == WAIT1) ? mem_rdata : '0;
    assign wordLo = (state == WAIT1) ? word0 : mem_rdata;

    load_extract #(
        .XLEN(XLEN)
    ) uExtract (
        .words ({wordHi, wordLo}),
        .off   (offQ),
        .funct3(f3Q),
        .data  (extData)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
            offQ          <= '0;
            f3Q           <= '0;
            crossQ        <= 1'b0;
            word0         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        offQ      <= reqOff;
                        f3Q       <= req_funct3;
                        crossQ    <= reqCross;
                        req_ready <= 1'b0;
                        if (reqLegal) begin
                            state         <= REQ0;
                            mem_req_valid <= 1'b1;
                            mem_addr      <= reqAligned;
                        end else begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                        end
                    end
                end
                REQ0: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT0;
                    end
                end
                WAIT0: begin
                    if (mem_rsp_valid) begin
                        word0 <= mem_rdata;
                        if (crossQ) begin
                            state         <= REQ1;
                            mem_req_valid <= 1'b1;
                            mem_addr      <= mem_addr + ADDR_W'(NB);
                        end else begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_data  <= extData;
                        end
                    end
                end
                REQ1: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT1;
                    end
                end
                WAIT1: begin
                    if (mem_rsp_valid) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_data  <= extData;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
